// File: rtl/pci_defs.sv
// rtl/pci_defs.sv - PCI command encodings and target state type
package pci_defs;

    localparam logic [3:0] CMD_IORD  = 4'b0010;
    localparam logic [3:0] CMD_IOWR  = 4'b0011;
    localparam logic [3:0] CMD_MEMRD = 4'b0110;
    localparam logic [3:0] CMD_MEMWR = 4'b0111;
    localparam logic [3:0] CMD_CFGRD = 4'b1010;
    localparam logic [3:0] CMD_CFGWR = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2,
        ST_TURN = 2'd3
    } tgt_state_e;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pci_io_regfile.sv
// rtl/pci_io_regfile.sv - DWORD register file, byte-enable write, registered read
module pci_io_regfile #(
    parameter int          DEPTH     = 12,
    parameter int          IDX_W     = 4,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (wr_en && (int'(wr_idx) < DEPTH)) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Out-of-range indices read as zero rather than aliasing another word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 32'h0;
        end else if (rd_en) begin
            rd_data <= (int'(rd_idx) < DEPTH) ? mem[rd_idx] : 32'h0;
        end
    end

endmodule

// File: rtl/pci_io_target.sv
// rtl/pci_io_target.sv - PCI I/O-space target with windowed register file
module pci_io_target
    import pci_defs::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_03B0,
    parameter logic [31:0] LIMIT_ADDR  = 32'h0000_03DF,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic        pci_clk_i,
    input  logic        pci_rst_ni,
    input  logic        pci_frame_ni,
    input  logic        pci_irdy_ni,
    input  logic [3:0]  pci_cbe_ni,
    input  logic [31:0] pci_ad_i,
    output logic [31:0] pci_ad_o,
    output logic        pci_ad_oe_o,
    output logic        pci_devsel_no,
    output logic        pci_trdy_no,
    output logic        pci_stop_no,
    output logic        pci_ctl_oe_o
);

    localparam logic [31:0] BASE_WORD = BASE_ADDR >> 2;
    localparam int          DEPTH     = int'((LIMIT_ADDR >> 2) - BASE_WORD) + 1;
    localparam int          IDX_W     = idx_width(DEPTH);
    localparam logic [2:0]  WS_LOAD   = 3'(WAIT_STATES - 1);

    tgt_state_e       state_q, state_d;
    logic             frame_q;
    logic             is_read_q;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       cnt_q;

    logic             addr_phase, is_io_cmd, in_window, hit;
    logic [IDX_W-1:0] dec_idx, rd_idx;
    logic             rd_en, wr_en;
    logic [31:0]      rd_data;

    assign addr_phase = !pci_frame_ni && frame_q && (state_q == ST_IDLE);
    assign is_io_cmd  = (pci_cbe_ni == CMD_IORD) || (pci_cbe_ni == CMD_IOWR);
    assign in_window  = (pci_ad_i >= BASE_ADDR) && (pci_ad_i <= LIMIT_ADDR);
    assign hit        = addr_phase && is_io_cmd && in_window;
    assign dec_idx    = IDX_W'((pci_ad_i >> 2) - BASE_WORD);
    // Zero-wait reads fetch straight from the decoded address so data is ready on DATA entry
    assign rd_idx     = (state_q == ST_IDLE) ? dec_idx : idx_q;

    always_ff @(posedge pci_clk_i or negedge pci_rst_ni) begin
        if (!pci_rst_ni) begin
            state_q   <= ST_IDLE;
            frame_q   <= 1'b1;
            is_read_q <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= pci_frame_ni;
            if (hit) begin
                idx_q     <= dec_idx;
                is_read_q <= ~pci_cbe_ni[0];
                cnt_q     <= WS_LOAD;
            end else if ((state_q == ST_WAIT) && (cnt_q != 3'd0)) begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_DATA;
                        rd_en   = ~pci_cbe_ni[0];
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (pci_frame_ni && pci_irdy_ni) begin
                    state_d = ST_TURN;
                end else if (cnt_q == 3'd0) begin
                    state_d = ST_DATA;
                    rd_en   = is_read_q;
                end
            end
            ST_DATA: begin
                if (!pci_irdy_ni) begin
                    wr_en   = ~is_read_q;
                    state_d = ST_TURN;
                end else if (pci_frame_ni) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode directly from state so an async reset releases them at once
    always_comb begin
        pci_devsel_no = 1'b1;
        pci_trdy_no   = 1'b1;
        pci_stop_no   = 1'b1;
        pci_ctl_oe_o  = 1'b0;
        pci_ad_oe_o   = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                pci_devsel_no = 1'b0;
                pci_ctl_oe_o  = 1'b1;
                pci_ad_oe_o   = is_read_q;
            end
            ST_DATA: begin
                pci_devsel_no = 1'b0;
                pci_trdy_no   = 1'b0;
                pci_stop_no   = 1'b0;
                pci_ctl_oe_o  = 1'b1;
                pci_ad_oe_o   = is_read_q;
            end
            ST_TURN: pci_ctl_oe_o = 1'b1;
            default: ;
        endcase
    end

    assign pci_ad_o = rd_data;

    pci_io_regfile #(
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk     (pci_clk_i),
        .rst_n   (pci_rst_ni),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_be   (~pci_cbe_ni),
        .wr_data (pci_ad_i),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

endmodule
